fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: owns the program counter and drives the instruction memory through a req/ack handshake. It delivers one instruction plus its PC+4 per cycle into the if/id registers consumed by decode. It applies decode's PC redirects with MIPS single-delay-slot semantics. It holds its output and any already-fetched instruction while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP, 32'h0000_0000, instruction word driven when if/id is empty
- clock  in  1  clock
- reset  in  1  asynchronous, active-low
- id_if_selpcsource  in  1  redirect request from decode (combinational on if_id_instruc)
- id_if_selpctype  in  2  target select: 00 branch, 01 register, 10 index, 11 treated as 00
- id_if_pcimd2ext  in  32  branch target
- id_if_rega  in  32  register (jr/jalr) target
- id_if_pcindex  in  32  jump-index target
- if_stall  in  1  freeze request (issue stall OR hazard stall)
- if_id_instruc  out  32  instruction presented to decode
- if_id_nextpc  out  32  address of if_id_instruc + 4
- if_id_valid  out  1  if_id_instruc is a real fetched instruction
- if_mem_addr  out  32  fetch address
- if_mem_req  out  1  fetch request
- mem_if_ack  in  1  data valid this cycle; may arrive the same cycle as req
- mem_if_data  in  32  instruction word, sampled only when req && ack

## Operation
- FSM states: IDLE, FETCH, HELD. IDLE exists only for the first cycle after reset and goes to FETCH unconditionally.
- FETCH: if_mem_req=1 and if_mem_addr=pc. addr stays stable until ack.
  - On ack with ~if_stall: if/id gets {data, pc+4, valid=1}; pc advances.
  - On ack with if_stall: data and pc+4 go into the skid register; pc advances; next state HELD.
- HELD: if_mem_req=0. When ~if_stall, skid contents move into if/id and the state returns to FETCH.
- Empty cycle: no ack, ~if_stall, not HELD. if/id gets {NOP, unchanged nextpc, valid=0}.
- if_stall=1: if/id registers hold every bit. Redirect inputs are ignored.
- PC advance: pc ← pc+4 mod 2^32, or the redirect target when one applies.
- Redirect acceptance: the cycle where if_id_valid && id_if_selpcsource && ~if_stall. The target is selected by selpctype.
- Delay slot: the instruction delivered after the branch is always the one at the branch's if_id_nextpc. It is never flushed.
  - Slot acked in the accept cycle, or already in skid (HELD exit): pc ← target directly.
  - Slot not yet acked: target latched into redir_pc and redir_pend=1. When the slot is acked, pc ← redir_pc and redir_pend clears.
- A redirect in a delay slot is accepted like any other redirect; no special case.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, if_id_instruc=NOP, if_id_nextpc=RESET_PC, if_id_valid=0, if_mem_req=0, if_mem_addr=RESET_PC, redir_pend=0, skid empty.
- Reset asserted mid-fetch: all of the above apply immediately. An outstanding ack is discarded.
- First req: the cycle after reset deasserts plus one (IDLE cycle).
- Ack in cycle t → if/id shows the instruction at t+1. Zero-wait memory sustains 1 instruction/cycle.
- Branch in if/id at t with slot acked at t: slot appears at t+1, target req at t+1, target in if/id at t+2. No bubble.
- Stall release from HELD: skid instruction is in if/id the next cycle; req reasserts the same cycle HELD exits.
- if_mem_addr and req are registered or state-derived only. There is no combinational path from mem_if_ack to req.

## Structure
- Shared package:
  - FSM state encoding
  - PCTYPE_BR=2'b00, PCTYPE_JR=2'b01, PCTYPE_J=2'b10
  - NOP default
- One combinational sub-module, pc_target_mux: selpctype plus the three targets → target.
- The FSM, skid register and redirect latch stay in fetch_unit.

## Test plan
- Reset, zero-wait memory returning addr-derived words → if_mem_addr 0,4,8,…; if_id_nextpc 4,8,12; valid=1 from the third cycle after reset.
- Memory acks every 3rd cycle → if_id_valid=0 with NOP in gap cycles; pc is unchanged until ack.
- Branch at 0x10, selpctype=00, pcimd2ext=0x40, zero-wait → if/id sequence 0x10, 0x14, 0x40, 0x44.
- Same branch, slot ack delayed 2 cycles → redir_pend set; next address after 0x14 is 0x40, with no extra fetch of 0x18.
- if_stall=1 for 3 cycles, arriving the same cycle as an ack → req drops, if/id holds. On release the skid instruction appears, then fetch resumes with no loss or duplication.
- jr (01, rega=0x1000) and j (10, pcindex=0x0800_0000) → fetch continues at the chosen target after the slot. selpctype=11 behaves like 00.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: data width, reset PC,
// NOP encoding, redirect target selects, FSM encoding and the if/id payload.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    // Redirect target selects; 2'b11 falls back to the branch target.
    localparam logic [1:0] PCTYPE_BR = 2'b00;
    localparam logic [1:0] PCTYPE_JR = 2'b01;
    localparam logic [1:0] PCTYPE_J  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HELD  = 2'd2
    } fetch_state_e;

    // One fetched instruction together with its fall-through address.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] nextpc;
    } ifid_payload_t;

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target select for the fetch stage.
//   selpctype : 00 branch, 01 register, 10 jump index, 11 branch
//   pcimd2ext / rega / pcindex : candidate targets
//   target_c  : selected target (combinational)
module pc_target_mux
    import fetch_unit_pkg::*;
(
    input  logic [1:0]      selpctype,
    input  logic [XLEN-1:0] pcimd2ext,
    input  logic [XLEN-1:0] rega,
    input  logic [XLEN-1:0] pcindex,
    output logic [XLEN-1:0] target_c
);

    always_comb begin
        target_c = pcimd2ext;
        case (selpctype)
            PCTYPE_BR: target_c = pcimd2ext;
            PCTYPE_JR: target_c = rega;
            PCTYPE_J:  target_c = pcindex;
            default:   target_c = pcimd2ext;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// fills the if/id registers, applies decode redirects with one delay slot
// and parks a fetched instruction in a skid register while stalled.
//   clock, reset (async, active-low)
//   id_if_*           : redirect request and candidate targets from decode
//   if_stall          : freeze if/id
//   if_id_*           : instruction, its address + 4, valid flag to decode
//   if_mem_* / mem_if_* : instruction memory request/ack/data
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            id_if_selpcsource,
    input  logic [1:0]      id_if_selpctype,
    input  logic [XLEN-1:0] id_if_pcimd2ext,
    input  logic [XLEN-1:0] id_if_rega,
    input  logic [XLEN-1:0] id_if_pcindex,
    input  logic            if_stall,
    output logic [XLEN-1:0] if_id_instruc,
    output logic [XLEN-1:0] if_id_nextpc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_mem_addr,
    output logic            if_mem_req,
    input  logic            mem_if_ack,
    input  logic [XLEN-1:0] mem_if_data
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_instruc_q, if_id_instruc_d;
    logic [XLEN-1:0] if_id_nextpc_q, if_id_nextpc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            if_mem_req_q, if_mem_req_d;
    ifid_payload_t   skid_q, skid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            redir_pend_q, redir_pend_d;

    logic [XLEN-1:0] target_c;
    logic            fetch_ack_c;
    logic            accept_c;

    pc_target_mux u_pc_target_mux (
        .selpctype (id_if_selpctype),
        .pcimd2ext (id_if_pcimd2ext),
        .rega      (id_if_rega),
        .pcindex   (id_if_pcindex),
        .target_c  (target_c)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_PC;
            if_id_instruc_q <= NOP;
            if_id_nextpc_q  <= RESET_PC;
            if_id_valid_q   <= 1'b0;
            if_mem_req_q    <= 1'b0;
            skid_q          <= '{instr: NOP, nextpc: RESET_PC};
            redir_pc_q      <= RESET_PC;
            redir_pend_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            if_id_instruc_q <= if_id_instruc_d;
            if_id_nextpc_q  <= if_id_nextpc_d;
            if_id_valid_q   <= if_id_valid_d;
            if_mem_req_q    <= if_mem_req_d;
            skid_q          <= skid_d;
            redir_pc_q      <= redir_pc_d;
            redir_pend_q    <= redir_pend_d;
        end
    end

    // Next-state, if/id, skid, PC and redirect latch.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        if_id_instruc_d = if_id_instruc_q;
        if_id_nextpc_d  = if_id_nextpc_q;
        if_id_valid_d   = if_id_valid_q;
        skid_d          = skid_q;
        redir_pc_d      = redir_pc_q;
        redir_pend_d    = redir_pend_q;

        fetch_ack_c = (state_q == ST_FETCH) && mem_if_ack;
        accept_c    = if_id_valid_q && id_if_selpcsource && !if_stall;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (fetch_ack_c && if_stall) state_d = ST_HELD;
            ST_HELD:  if (!if_stall) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase

        // if/id update; a stall freezes every bit.
        if (!if_stall) begin
            if (state_q == ST_HELD) begin
                if_id_instruc_d = skid_q.instr;
                if_id_nextpc_d  = skid_q.nextpc;
                if_id_valid_d   = 1'b1;
            end else if (fetch_ack_c) begin
                if_id_instruc_d = mem_if_data;
                if_id_nextpc_d  = pc_q + PC_STEP;
                if_id_valid_d   = 1'b1;
            end else begin
                if_id_instruc_d = NOP;
                if_id_valid_d   = 1'b0;
            end
        end

        if (fetch_ack_c && if_stall) begin
            skid_d = '{instr: mem_if_data, nextpc: pc_q + PC_STEP};
        end

        // The instruction after a redirecting one is its delay slot. If that
        // slot is already fetched (acked now or parked in skid) the target
        // goes straight to the PC; otherwise it waits for the slot's ack.
        if (fetch_ack_c) begin
            if (accept_c) begin
                pc_d = target_c;
            end else if (redir_pend_q) begin
                pc_d         = redir_pc_q;
                redir_pend_d = 1'b0;
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end else if (accept_c) begin
            if (state_q == ST_HELD) begin
                pc_d = target_c;
            end else begin
                redir_pc_d   = target_c;
                redir_pend_d = 1'b1;
            end
        end

        // Request follows the state being entered, so ack never reaches req.
        if_mem_req_d = (state_d == ST_FETCH);
    end

    assign if_id_instruc = if_id_instruc_q;
    assign if_id_nextpc  = if_id_nextpc_q;
    assign if_id_valid   = if_id_valid_q;
    assign if_mem_addr   = pc_q;
    assign if_mem_req    = if_mem_req_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory with programmable wait states returning
// address-derived words, a decode stand-in issuing one redirect from 0x10,
// a queue-based reference model compared every cycle, and literal sequences.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic        if_stall = 1'b0;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        if_id_valid;
    logic [31:0] if_mem_addr;
    logic        if_mem_req;
    logic        mem_if_ack;
    logic [31:0] mem_if_data;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_rega        (id_if_rega),
        .id_if_pcindex     (id_if_pcindex),
        .if_stall          (if_stall),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .if_id_valid       (if_id_valid),
        .if_mem_addr       (if_mem_addr),
        .if_mem_req        (if_mem_req),
        .mem_if_ack        (mem_if_ack),
        .mem_if_data       (mem_if_data)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus configuration.
    int          base_wait = 0;
    logic        slow_en   = 1'b0;
    logic [31:0] slow_addr = 32'h14;
    logic        br_en     = 1'b0;
    logic [1:0]  br_type   = 2'b00;
    logic [31:0] rega_v    = 32'h1000;
    logic [31:0] pcindex_v = 32'h0800_0000;

    // Decode stand-in: the instruction at 0x10 redirects.
    assign id_if_selpcsource = br_en && (if_id_nextpc == 32'h14);
    assign id_if_selpctype   = br_type;
    assign id_if_pcimd2ext   = 32'h40;
    assign id_if_rega        = rega_v;
    assign id_if_pcindex     = pcindex_v;

    // Memory: ack once the request has waited the required cycles.
    int wait_cnt;
    assign mem_if_ack  = if_mem_req && (wait_cnt >= ((slow_en && if_mem_addr == slow_addr) ? 2 : base_wait));
    assign mem_if_data = if_mem_addr ^ 32'h5EED_0000;

    always @(posedge clock or negedge reset) begin
        if (!reset)          wait_cnt <= 0;
        else if (if_mem_req) wait_cnt <= mem_if_ack ? 0 : wait_cnt + 1;
    end

    // Reference model: next fetch address, fetched-not-delivered buffer,
    // targets waiting for their delay slot, and the if/id view.
    logic        m_started;
    logic [31:0] m_pc, m_instr, m_npc;
    logic        m_valid;
    logic [63:0] m_buf[$];
    logic [31:0] m_pend[$];
    logic        m_acked, m_accept;
    logic [31:0] m_tgt;
    logic [63:0] m_ent;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_started = 1'b0;
            m_pc      = 32'h0;
            m_instr   = 32'h0;
            m_npc     = 32'h0;
            m_valid   = 1'b0;
            m_buf.delete();
            m_pend.delete();
        end else begin
            m_acked  = m_started && (m_buf.size() == 0) && mem_if_ack;
            m_accept = m_valid && br_en && (m_npc == 32'h14) && !if_stall;
            m_tgt    = (br_type == 2'b01) ? rega_v : (br_type == 2'b10) ? pcindex_v : 32'h40;
            if (m_acked) begin
                m_buf.push_back({m_pc ^ 32'h5EED_0000, m_pc + 32'd4});
                if (m_accept)               m_pc = m_tgt;
                else if (m_pend.size() > 0) m_pc = m_pend.pop_front();
                else                        m_pc = m_pc + 32'd4;
            end else if (m_accept) begin
                if (m_buf.size() > 0) m_pc = m_tgt;
                else                  m_pend.push_back(m_tgt);
            end
            if (!if_stall) begin
                if (m_buf.size() > 0) begin
                    m_ent   = m_buf.pop_front();
                    m_instr = m_ent[63:32];
                    m_npc   = m_ent[31:0];
                    m_valid = 1'b1;
                end else begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end
            end
            m_started = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Observed fetch addresses and delivered instruction addresses.
    logic [31:0] alog[$];
    logic [31:0] dlog[$];
    logic        stall_at_edge;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            alog.delete();
            stall_at_edge <= 1'b0;
        end else begin
            stall_at_edge <= if_stall;
            if (if_mem_req && mem_if_ack) alog.push_back(if_mem_addr);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (!reset) dlog.delete();
        else if (if_id_valid && !stall_at_edge) dlog.push_back(if_id_nextpc - 32'd4);
        chk("if_id_instruc", if_id_instruc, m_instr);
        chk("if_id_nextpc", if_id_nextpc, m_npc);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("if_mem_req", {31'b0, if_mem_req}, {31'b0, m_started && (m_buf.size() == 0)});
        chk("if_mem_addr", if_mem_addr, m_pc);
    end

    task automatic chk_seq(input string nm, input logic [31:0] exp[$], input logic [31:0] got[$]);
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp[i]);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic stall_when(input logic [31:0] npc);
        int n;
        n = 0;
        while (!(m_valid && m_npc == npc) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_trigger: got no if_id_nextpc=%h, expected it within 60 cycles", npc);
        end
    endtask

    task automatic run_test(input string nm, input int bw, input logic slow, input logic br,
                            input logic [1:0] ty, input logic [31:0] idx, input logic stall,
                            input logic [31:0] stall_npc, input int cycles,
                            input logic [31:0] exp_d[$], input logic [31:0] exp_a[$]);
        base_wait = bw;
        slow_en   = slow;
        br_en     = br;
        br_type   = ty;
        pcindex_v = idx;
        if_stall  = 1'b0;
        do_reset();
        if (stall) begin
            stall_when(stall_npc);
            if_stall = 1'b1;
            repeat (3) @(negedge clock);
            if_stall = 1'b0;
        end
        repeat (cycles) @(negedge clock);
        chk_seq({nm, "_ifid"}, exp_d, dlog);
        chk_seq({nm, "_fetch"}, exp_a, alog);
    endtask

    logic [31:0] ed[$];
    logic [31:0] ea[$];

    initial begin
        // Reset release and first-request latency.
        base_wait = 0; slow_en = 1'b0; br_en = 1'b1; br_type = 2'b00;
        do_reset();
        chk("idle_req", {31'b0, if_mem_req}, 32'd0);
        chk("idle_addr", if_mem_addr, 32'h0);
        @(negedge clock);
        chk("first_req", {31'b0, if_mem_req}, 32'd1);
        chk("first_valid", {31'b0, if_id_valid}, 32'd0);
        @(negedge clock);
        chk("first_instr", if_id_instruc, 32'h5EED_0000);
        chk("first_nextpc", if_id_nextpc, 32'h4);
        chk("first_valid1", {31'b0, if_id_valid}, 32'd1);
        chk("second_addr", if_mem_addr, 32'h4);
        repeat (12) @(negedge clock);
        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44};
        chk_seq("br_zero_wait_ifid", ed, dlog);
        chk_seq("br_zero_wait_fetch", ed, alog);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC};
        run_test("ack_every_3rd", 2, 1'b0, 1'b0, 2'b00, 32'h0800_0000, 1'b0, 32'h0, 20, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44};
        run_test("slot_delayed", 0, 1'b1, 1'b1, 2'b00, 32'h0800_0000, 1'b0, 32'h0, 16, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
        run_test("stall_on_ack", 0, 1'b0, 1'b0, 2'b00, 32'h0800_0000, 1'b1, 32'hC, 8, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44};
        run_test("stall_branch", 0, 1'b0, 1'b1, 2'b00, 32'h0800_0000, 1'b1, 32'h14, 8, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h1000, 32'h1004};
        run_test("jr", 0, 1'b0, 1'b1, 2'b01, 32'h0800_0000, 1'b0, 32'h0, 12, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h0800_0000, 32'h0800_0004};
        run_test("j", 0, 1'b0, 1'b1, 2'b10, 32'h0800_0000, 1'b0, 32'h0, 12, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h44};
        run_test("type11", 0, 1'b0, 1'b1, 2'b11, 32'h0800_0000, 1'b0, 32'h0, 12, ed, ed);

        ed = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        run_test("pc_wrap", 0, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFF8, 1'b0, 32'h0, 14, ed, ed);

        // Reset asserted asynchronously in the middle of a fetch.
        base_wait = 0; slow_en = 1'b0; br_en = 1'b0;
        do_reset();
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_instr", if_id_instruc, 32'h0);
        chk("midrst_nextpc", if_id_nextpc, 32'h0);
        chk("midrst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("midrst_req", {31'b0, if_mem_req}, 32'd0);
        chk("midrst_addr", if_mem_addr, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        ed = '{32'h0, 32'h4, 32'h8, 32'hC};
        chk_seq("midrst_ifid", ed, dlog);
        chk_seq("midrst_fetch", ed, alog);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
